booth_div_seq: RTL and testbench

- Iterative signed divider: 2*DW-bit dividend by DW-bit divisor, giving a DW-bit quotient and a DW-bit remainder.
- Inverse datapath of the 16x16 Booth/Dadda multiplier. Product-width values (32 bits) are divided back down to operand width (16 bits).
- Shift/subtract on magnitudes, one quotient bit per clock, valid/ready handshakes on both sides.
- Used wherever the design must undo or normalise a multiplier result.

---
 rtl/booth_div_seq.sv | 168 ++++++++++++++++
 tb/tb_booth_div_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_div_seq.sv
// Iterative signed divider: 2*DW-bit dividend by DW-bit divisor.
// Restoring shift/subtract on magnitudes, one quotient bit per clock,
// followed by a sign/range fix-up cycle.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid / in_ready      operand handshake (dividend, divisor)
//   out_valid / out_ready    result handshake (quotient, remainder, ovf, div_zero)
module booth_div_seq #(
  parameter int unsigned DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DW-1:0]   dividend,
  input  logic [DW-1:0]     divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     quotient,
  output logic [DW-1:0]     remainder,
  output logic              ovf,
  output logic              div_zero
);

  localparam int unsigned AW = 2 * DW;
  localparam int unsigned CW = $clog2(AW);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic signed [AW:0] QMAX = (AW+1)'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW:0] QMIN = ~QMAX;

  logic [1:0]    state, state_n;
  logic [AW-1:0] dmag, dmag_n;      // dividend magnitude, becomes quotient magnitude
  logic [DW:0]   dvs, dvs_n;        // divisor magnitude
  logic [DW:0]   prem, prem_n;      // partial remainder
  logic          neg_q, neg_q_n;
  logic          neg_r, neg_r_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          in_ready_n, out_valid_n, ovf_n, div_zero_n;
  logic [DW-1:0] quotient_n, remainder_n;

  logic [DW+1:0]        sh;
  logic [AW-1:0]        amag;
  logic [DW:0]          dvx;
  logic [DW:0]          bmag;
  logic [AW:0]          qmag;
  logic signed [AW:0]   qs;

  // Next-state and datapath
  always_comb begin
    state_n     = state;
    dmag_n      = dmag;
    dvs_n       = dvs;
    prem_n      = prem;
    neg_q_n     = neg_q;
    neg_r_n     = neg_r;
    cnt_n       = cnt;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    ovf_n       = ovf;
    div_zero_n  = div_zero;
    quotient_n  = quotient;
    remainder_n = remainder;

    sh   = {prem, dmag[AW-1]};
    amag = dividend[AW-1] ? -dividend : dividend;
    dvx  = {divisor[DW-1], divisor};
    bmag = dvx[DW] ? -dvx : dvx;
    qmag = {1'b0, dmag};
    qs   = neg_q ? -qmag : qmag;

    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          dmag_n     = amag;
          dvs_n      = bmag;
          neg_q_n    = dividend[AW-1] ^ divisor[DW-1];
          neg_r_n    = dividend[AW-1];
          prem_n     = '0;
          cnt_n      = '0;
          in_ready_n = 1'b0;
          ovf_n      = 1'b0;
          div_zero_n = 1'b0;
          if (divisor == '0) begin
            quotient_n  = '1;
            remainder_n = dividend[DW-1:0];
            div_zero_n  = 1'b1;
            out_valid_n = 1'b1;
            state_n     = S_DONE;
          end else begin
            state_n = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (sh >= {1'b0, dvs}) begin
          prem_n = (DW+1)'(sh - {1'b0, dvs});
          dmag_n = {dmag[AW-2:0], 1'b1};
        end else begin
          prem_n = sh[DW:0];
          dmag_n = {dmag[AW-2:0], 1'b0};
        end
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(AW - 1)) state_n = S_FIX;
      end
      S_FIX: begin
        // Remainder magnitude is below |divisor| <= 2^(DW-1), so DW bits hold it
        remainder_n = neg_r ? DW'(-prem) : DW'(prem);
        if (qs > QMAX) begin
          ovf_n      = 1'b1;
          quotient_n = {1'b0, {(DW-1){1'b1}}};
        end else if (qs < QMIN) begin
          ovf_n      = 1'b1;
          quotient_n = {1'b1, {(DW-1){1'b0}}};
        end else begin
          quotient_n = qs[DW-1:0];
        end
        out_valid_n = 1'b1;
        state_n     = S_DONE;
      end
      default: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
          state_n     = S_IDLE;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      dmag      <= '0;
      dvs       <= '0;
      prem      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state     <= state_n;
      dmag      <= dmag_n;
      dvs       <= dvs_n;
      prem      <= prem_n;
      neg_q     <= neg_q_n;
      neg_r     <= neg_r_n;
      cnt       <= cnt_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      ovf       <= ovf_n;
      div_zero  <= div_zero_n;
      quotient  <= quotient_n;
      remainder <= remainder_n;
    end
  end

endmodule

// File: tb/tb_booth_div_seq.sv
// Self-checking bench for booth_div_seq: arithmetic reference model,
// per-cycle output checker, directed literal cases and random traffic.
module tb_booth_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        ovf;
  logic        div_zero;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];

  booth_div_seq #(.DW(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: plain signed division with truncation toward zero
  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
    exp_t   m;
    longint sa, sb, qt, rt;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      m.q = 16'hFFFF; m.r = a[15:0]; m.ovf = 1'b0; m.dz = 1'b1;
    end else begin
      qt = sa / sb;
      rt = sa % sb;
      m.dz = 1'b0;
      m.r  = rt[15:0];
      if (qt > 32767) begin
        m.ovf = 1'b1; m.q = 16'h7FFF;
      end else if (qt < -32768) begin
        m.ovf = 1'b1; m.q = 16'h8000;
      end else begin
        m.ovf = 1'b0; m.q = qt[15:0];
      end
    end
    return m;
  endfunction

  // Every cycle a result is presented, it must match the oldest accepted operation
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        chk("quotient", 64'(quotient), 64'(exp_q[0].q));
        chk("remainder", 64'(remainder), 64'(exp_q[0].r));
        chk("ovf", 64'(ovf), 64'(exp_q[0].ovf));
        chk("div_zero", 64'(div_zero), 64'(exp_q[0].dz));
        chk("in_ready_while_valid", 64'(in_ready), 64'd0);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int hold,
                        output int lat, output exp_t cap);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    out_ready = (hold == 0);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    exp_q.push_back(model(a, b));
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    chk("out_valid_timeout", 64'(out_valid), 64'd1);
    cap = '{quotient, remainder, ovf, div_zero};
    for (int i = 0; i < hold; i++) begin
      chk("in_ready_in_done", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      dividend = $urandom;
      divisor  = 16'($urandom);
      tick();
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_after", 64'(in_ready), 64'd1);
  endtask

  task automatic expect_lit(input string name, input exp_t cap, input logic [15:0] q,
                            input logic [15:0] r, input logic o, input logic dz);
    chk({name, "_q"}, 64'(cap.q), 64'(q));
    chk({name, "_r"}, 64'(cap.r), 64'(r));
    chk({name, "_ovf"}, 64'(cap.ovf), 64'(o));
    chk({name, "_dz"}, 64'(cap.dz), 64'(dz));
  endtask

  initial begin
    int          lat;
    int          seen;
    exp_t        cap;
    logic [15:0] ra, rb;
    logic signed [31:0] prod;
    logic [31:0] da;
    logic [15:0] db;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    rst = 1'b0;
    tick();

    run_op(32'd100, 16'd7, 0, lat, cap);
    chk("latency_normal", 64'(lat), 64'd34);
    expect_lit("pos", cap, 16'h000E, 16'h0002, 1'b0, 1'b0);

    run_op(32'hFFFFFF9C, 16'd7, 0, lat, cap);
    expect_lit("neg_dividend", cap, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0);

    run_op(32'd100, 16'hFFF9, 1, lat, cap);
    expect_lit("neg_divisor", cap, 16'hFFF2, 16'h0002, 1'b0, 1'b0);

    run_op(32'h40000000, 16'h8000, 0, lat, cap);
    expect_lit("range_edge", cap, 16'h8000, 16'h0000, 1'b0, 1'b0);

    run_op(32'h80000000, 16'hFFFF, 0, lat, cap);
    expect_lit("min_by_m1", cap, 16'h7FFF, 16'h0000, 1'b1, 1'b0);

    run_op(32'h00010000, 16'd1, 0, lat, cap);
    expect_lit("ovf_pos", cap, 16'h7FFF, 16'h0000, 1'b1, 1'b0);

    run_op(32'hFFFF0000, 16'd1, 0, lat, cap);
    expect_lit("ovf_neg", cap, 16'h8000, 16'h0000, 1'b1, 1'b0);

    run_op(32'd1234, 16'd0, 0, lat, cap);
    chk("latency_div0", 64'(lat), 64'd1);
    expect_lit("div0", cap, 16'hFFFF, 16'h04D2, 1'b0, 1'b1);

    run_op(32'd100, 16'd7, 5, lat, cap);
    expect_lit("after_div0_hold", cap, 16'h000E, 16'h0002, 1'b0, 1'b0);

    // Multiplier round trip: A*B / B must give back A exactly
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (rb == 16'd0) rb = 16'd3;
      prod = $signed(ra) * $signed(rb);
      run_op(prod, rb, i % 3, lat, cap);
      chk("roundtrip_q", 64'(cap.q), 64'(ra));
      chk("roundtrip_r", 64'(cap.r), 64'd0);
    end

    // Random operands, with zero and tiny divisors mixed in to reach overflow
    for (int i = 0; i < 30; i++) begin
      da = $urandom;
      case ($urandom_range(0, 9))
        0:       db = 16'd0;
        1, 2, 3: db = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(1, 3))
                                                  : -16'($urandom_range(1, 3));
        default: db = 16'($urandom);
      endcase
      run_op(da, db, $urandom_range(0, 2), lat, cap);
    end

    // Reset during CALC abandons the operation
    while (!in_ready) tick();
    dividend = 32'd100; divisor = 16'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_quotient", 64'(quotient), 64'd0);
    chk("midrst_remainder", 64'(remainder), 64'd0);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    chk("midrst_div_zero", 64'(div_zero), 64'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);

    run_op(32'd100, 16'd7, 0, lat, cap);
    expect_lit("post_rst", cap, 16'h000E, 16'h0002, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
